mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch / data) in front of a single memory port.
// Define MEM_PORT_ARBITER_STARVE_GUARD_EN to enable the fetch starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rd_data_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [1:0]        dm_size_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wr_data_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rd_data_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [1:0]        mem_size_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wr_data_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  input  logic              mem_ack_i
);

  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_DM = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   owner_dm;
  logic   flushed;
  logic   grant_if, grant_dm;
  logic   force_if;
  logic   if_ack_nxt, dm_ack_nxt;

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_range
    $error("STARVE_MAX must lie in 1..15");
  end

`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  // Consecutive data grants made while a fetch was waiting
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      starve_cnt <= 4'd0;
    end else if (grant_dm && if_req_i) begin
      starve_cnt <= starve_cnt + 4'd1;
    end else if (grant_dm || grant_if) begin
      starve_cnt <= 4'd0;
    end
  end

  assign force_if = if_req_i && (starve_cnt == 4'(STARVE_MAX));
`else
  assign force_if = 1'b0;
`endif

  // Arbitration: decide only in IDLE and not while a completion pulse is out,
  // because the finishing requester still holds its request in that cycle.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state == IDLE && !if_ack_o && !dm_ack_o) begin
      if (dm_req_i && !force_if) begin
        grant_dm = 1'b1;
      end else if (if_req_i) begin
        grant_if = 1'b1;
      end else begin
        grant_if = 1'b0;
      end
    end else begin
      grant_dm = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_dm) begin
          state_nxt = GRANT_DM;
        end else if (grant_if) begin
          state_nxt = GRANT_IF;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT_IF, GRANT_DM: begin
        if (mem_ack_i) begin
          state_nxt = RESP;
        end else begin
          state_nxt = state;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Completion pulses, registered on the edge that leaves RESP
  always_comb begin
    if_ack_nxt = 1'b0;
    dm_ack_nxt = 1'b0;
    if (state == RESP) begin
      dm_ack_nxt = owner_dm;
      if_ack_nxt = !owner_dm && !flushed && !if_flush_i;
    end else begin
      if_ack_nxt = 1'b0;
    end
  end

  // Memory-port request registers, read-data capture and flush tracking
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      if_ack_o      <= 1'b0;
      dm_ack_o      <= 1'b0;
      if_rd_data_o  <= '0;
      dm_rd_data_o  <= '0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_size_o    <= 2'd0;
      mem_addr_o    <= '0;
      mem_wr_data_o <= '0;
      owner_dm      <= 1'b0;
      flushed       <= 1'b0;
    end else begin
      if_ack_o <= if_ack_nxt;
      dm_ack_o <= dm_ack_nxt;
      if (grant_dm) begin
        mem_req_o     <= 1'b1;
        mem_we_o      <= dm_we_i;
        mem_size_o    <= dm_size_i;
        mem_addr_o    <= dm_addr_i;
        mem_wr_data_o <= dm_wr_data_i;
        owner_dm      <= 1'b1;
      end else if (grant_if) begin
        mem_req_o     <= 1'b1;
        mem_we_o      <= 1'b0;
        mem_size_o    <= SIZE_WORD;
        mem_addr_o    <= if_addr_i;
        mem_wr_data_o <= '0;
        owner_dm      <= 1'b0;
      end else if (mem_ack_i && state == GRANT_DM) begin
        mem_req_o    <= 1'b0;
        dm_rd_data_o <= mem_rd_data_i;
      end else if (mem_ack_i && state == GRANT_IF) begin
        mem_req_o    <= 1'b0;
        if_rd_data_o <= mem_rd_data_i;
      end
      if (grant_if || grant_dm) begin
        flushed <= 1'b0;
      end else if (if_flush_i && !owner_dm && (state == GRANT_IF || state == RESP)) begin
        flushed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written flush / reset / starvation
// sequences and a randomized run scored against a cycle-timeline model of the arbiter.
module tb_mem_port_arbiter;
  localparam int SM = 4;
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [1:0]  dm_size = 2'd0;
  logic [31:0] dm_addr = 32'd0, dm_wr_data = 32'd0;
  logic [31:0] mem_rd_data = 32'd0;
  logic        mem_ack = 1'b0;
  logic        if_ack_o, dm_ack_o, mem_req_o, mem_we_o;
  logic [31:0] if_rd_data_o, dm_rd_data_o, mem_addr_o, mem_wr_data_o;
  logic [1:0]  mem_size_o;

  int n_chk = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_ack_o(if_ack_o), .if_rd_data_o(if_rd_data_o),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_size_i(dm_size), .dm_addr_i(dm_addr),
    .dm_wr_data_i(dm_wr_data), .dm_ack_o(dm_ack_o), .dm_rd_data_o(dm_rd_data_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
    .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_rd_data_i(mem_rd_data), .mem_ack_i(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_req, dm_req, dm_we;
    logic [1:0]  dm_size;
    logic [31:0] if_addr, dm_addr, wr_data, rdata;
    int          lat;
    logic        exp_dm, exp_we;
    logic [1:0]  exp_size;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Serve one access whose request was raised in the current cycle.
  task automatic run_txn(input logic exp_dm, input logic [31:0] exp_addr, input logic exp_we,
                         input logic [1:0] exp_size, input logic [31:0] exp_wd,
                         input int lat, input logic [31:0] rdata);
    int t = 0;
    step();
    while (!mem_req_o && t < 20) begin
      step();
      t++;
    end
    chk("grant_wait", t, 0);
    chk("mem_addr", mem_addr_o, exp_addr);
    chk("mem_we", mem_we_o, exp_we);
    chk("mem_size", mem_size_o, exp_size);
    if (exp_we) chk("mem_wr_data", mem_wr_data_o, exp_wd);
    for (int i = 0; i < lat; i++) begin
      chk("mem_req_hold", mem_req_o, 1'b1);
      chk("mem_addr_hold", mem_addr_o, exp_addr);
      chk("mem_we_hold", mem_we_o, exp_we);
      step();
    end
    mem_ack = 1'b1;
    mem_rd_data = rdata;
    step();
    mem_ack = 1'b0;
    mem_rd_data = $urandom;
    chk("mem_req_drop", mem_req_o, 1'b0);
    chk("ack_early", {if_ack_o, dm_ack_o}, 2'b00);
    step();
    chk("if_ack", if_ack_o, !exp_dm);
    chk("dm_ack", dm_ack_o, exp_dm);
    if (exp_dm) begin
      chk("dm_rd_data", dm_rd_data_o, rdata);
      dm_req = 1'b0;
    end else begin
      chk("if_rd_data", if_rd_data_o, rdata);
      if_req = 1'b0;
    end
    step();
    chk("ack_pulse_end", {if_ack_o, dm_ack_o}, 2'b00);
  endtask

  // Timeline model state for the randomized run
  logic        m_active, m_acked, m_dm, m_we;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wd, exp_if_d, exp_dm_d;
  int          m_g, m_a, m_cnt, wait_left;
  logic        exp_req, exp_ia, exp_da;

  initial begin
    //             if dm we sz  if_addr       dm_addr       wr_data       rdata         lat dm we sz exp_addr
    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 2, 1'b0, 1'b0, 2'd2, 32'h100};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 2'd2, 32'h300, 32'h200, 32'h12345678, 32'h0, 0, 1'b1, 1'b1, 2'd2, 32'h200};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h44, 32'h0, 32'hA5A50001, 1, 1'b1, 1'b0, 2'd0, 32'h44};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 2'd1, 32'h104, 32'h86, 32'h0000BEEF, 32'h0F0F0F0F, 3, 1'b1, 1'b1, 2'd1, 32'h86};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h108, 32'h0, 32'h0, 32'h13579BDF, 0, 1'b0, 1'b0, 2'd2, 32'h108};

    step();
    step();
    reset_i = 1'b0;
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_we", mem_we_o, 1'b0);
    chk("rst_acks", {if_ack_o, dm_ack_o}, 2'b00);
    chk("rst_if_rd", if_rd_data_o, 32'h0);
    chk("rst_dm_rd", dm_rd_data_o, 32'h0);

    for (int i = 0; i < 5; i++) begin
      if_req = vecs[i].if_req;   if_addr = vecs[i].if_addr;
      dm_req = vecs[i].dm_req;   dm_we = vecs[i].dm_we;  dm_size = vecs[i].dm_size;
      dm_addr = vecs[i].dm_addr; dm_wr_data = vecs[i].wr_data;
      run_txn(vecs[i].exp_dm, vecs[i].exp_addr, vecs[i].exp_we, vecs[i].exp_size,
              vecs[i].wr_data, vecs[i].lat, vecs[i].rdata);
      if (vecs[i].if_req && vecs[i].dm_req)
        run_txn(1'b0, vecs[i].if_addr, 1'b0, 2'd2, 32'h0, 1, ~vecs[i].rdata);
    end

    // Flushed fetch: access completes, no if_ack_o, next IDLE cycle takes a new request
    if_req = 1'b1; if_addr = 32'h400;
    step();
    chk("flush_mem_req", mem_req_o, 1'b1);
    if_flush = 1'b1; if_req = 1'b0;
    step();
    if_flush = 1'b0; mem_ack = 1'b1; mem_rd_data = 32'hCAFE0001;
    step();
    mem_ack = 1'b0;
    chk("flush_mem_req_drop", mem_req_o, 1'b0);
    chk("flush_if_ack_resp", if_ack_o, 1'b0);
    dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'd2; dm_addr = 32'h500;
    step();
    chk("flush_if_ack", if_ack_o, 1'b0);
    chk("resp_ignores_req", mem_req_o, 1'b0);
    run_txn(1'b1, 32'h500, 1'b0, 2'd2, 32'h0, 0, 32'h77665544);

    // Reset during GRANT_DM with a late memory ack
    dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'd1; dm_addr = 32'h800; dm_wr_data = 32'h55AA55AA;
    step();
    chk("rmid_mem_req", mem_req_o, 1'b1);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0; dm_req = 1'b0; mem_ack = 1'b1; mem_rd_data = 32'hBADBAD00;
    chk("rmid_mem_req_rst", mem_req_o, 1'b0);
    chk("rmid_mem_we_rst", mem_we_o, 1'b0);
    chk("rmid_acks_rst", {if_ack_o, dm_ack_o}, 2'b00);
    chk("rmid_if_rd_rst", if_rd_data_o, 32'h0);
    chk("rmid_dm_rd_rst", dm_rd_data_o, 32'h0);
    step();
    mem_ack = 1'b0;
    chk("rmid_late_ack_req", mem_req_o, 1'b0);
    chk("rmid_late_ack_rd", dm_rd_data_o, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("rmid_no_dm_ack", dm_ack_o, 1'b0);
      step();
    end

    // Starvation: fetch held, data request re-asserted after every completion
    if_req = 1'b1; if_addr = 32'h600;
    dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'd2; dm_addr = 32'h700;
    for (int i = 0; i < 5; i++) begin
      logic exp_dm;
      exp_dm = !(GUARD && i == SM);
      run_txn(exp_dm, exp_dm ? 32'h700 : 32'h600, 1'b0, 2'd2, 32'h0, 0, 32'h1000 + i);
      dm_req = 1'b1;
    end
    dm_req = 1'b0; if_req = 1'b1;
    run_txn(1'b0, 32'h600, 1'b0, 2'd2, 32'h0, 0, 32'h2000);

    // Randomized run against the timeline model
    reset_i = 1'b1; if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    step();
    reset_i = 1'b0;
    m_active = 1'b0; m_acked = 1'b0; m_dm = 1'b0; m_g = 0; m_a = 0; m_cnt = 0; wait_left = 0;
    m_we = 1'b0; m_size = 2'd0; m_addr = 32'h0; m_wd = 32'h0;
    exp_if_d = 32'h0; exp_dm_d = 32'h0;
    for (int k = 0; k < 3000; k++) begin
      exp_req = m_active && (k > m_g) && !(m_acked && k > m_a);
      exp_ia  = m_active && m_acked && !m_dm && (k == m_a + 2);
      exp_da  = m_active && m_acked && m_dm && (k == m_a + 2);
      chk("rnd_mem_req", mem_req_o, exp_req);
      chk("rnd_if_ack", if_ack_o, exp_ia);
      chk("rnd_dm_ack", dm_ack_o, exp_da);
      chk("rnd_if_rd", if_rd_data_o, exp_if_d);
      chk("rnd_dm_rd", dm_rd_data_o, exp_dm_d);
      if (exp_req) begin
        chk("rnd_mem_addr", mem_addr_o, m_addr);
        chk("rnd_mem_we", mem_we_o, m_we);
        chk("rnd_mem_size", mem_size_o, m_size);
        if (m_we) chk("rnd_mem_wd", mem_wr_data_o, m_wd);
      end
      if (exp_ia) if_req = 1'b0;
      if (exp_da) dm_req = 1'b0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom & 32'hFFFFFFFC;
      end
      if (!dm_req && $urandom_range(0, 3) != 0) begin
        dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_size = 2'($urandom_range(0, 2));
        dm_addr = $urandom; dm_wr_data = $urandom;
      end
      if (exp_req) begin
        if (k == m_g + 1) wait_left = $urandom_range(0, 3);
        if (wait_left == 0) begin
          mem_ack = 1'b1; mem_rd_data = $urandom;
        end else begin
          mem_ack = 1'b0; wait_left--;
        end
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0); mem_rd_data = $urandom;
      end
      if (exp_req && mem_ack) begin
        m_acked = 1'b1; m_a = k;
        if (m_dm) exp_dm_d = mem_rd_data;
        else exp_if_d = mem_rd_data;
      end
      if ((!m_active || (m_acked && k >= m_a + 3)) && (if_req || dm_req)) begin
        m_dm = dm_req && !(GUARD && if_req && m_cnt == SM);
        if (m_dm) m_cnt = if_req ? m_cnt + 1 : 0;
        else m_cnt = 0;
        m_active = 1'b1; m_g = k; m_acked = 1'b0;
        m_addr = m_dm ? dm_addr : if_addr;
        m_we   = m_dm ? dm_we : 1'b0;
        m_size = m_dm ? dm_size : 2'd2;
        m_wd   = dm_wr_data;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
